// File: rtl/mlp_sched_pkg.sv
// Shared definitions for the image sequencer: state encoding, default
// geometry and the class code stored when a result times out.
package mlp_sched_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRIME    = 3'd1,
        STREAM   = 3'd2,
        WAIT_RES = 3'd3,
        FINISH   = 3'd4
    } sched_state_e;

    localparam int DEF_NUM_IMAGES = 32;
    localparam int DEF_IMAGE_SIZE = 64;
    localparam int DEF_ADDR_W     = 13;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_CLASS_W    = 4;

    // Entry written when the watchdog gives up on a result.
    localparam logic [DEF_CLASS_W-1:0] TIMEOUT_CLASS = '1;

    // Requested image count limited to what the ROM actually holds.
    function automatic logic [7:0] clamp_images(input logic [7:0] req, input int max_n);
        return (int'(req) > max_n) ? 8'(max_n) : req;
    endfunction

endpackage

// File: rtl/mlp_image_sched_if.sv
// Datapath bundle between the sequencer, the image ROM, the layer-1 input
// port and the max-finder result port.
interface mlp_image_sched_if #(
    parameter int ADDR_W  = mlp_sched_pkg::DEF_ADDR_W,
    parameter int DATA_W  = mlp_sched_pkg::DEF_DATA_W,
    parameter int CLASS_W = mlp_sched_pkg::DEF_CLASS_W
);
    logic               rom_en;
    logic [ADDR_W-1:0]  rom_addr;
    logic [DATA_W-1:0]  rom_data;
    logic               x_valid;
    logic [DATA_W-1:0]  x_data;
    logic               res_valid;
    logic [CLASS_W-1:0] res_class;

    // Sequencer side.
    modport master (
        output rom_en, rom_addr, x_valid, x_data,
        input  rom_data, res_valid, res_class
    );

    // ROM / layer / max-finder side.
    modport slave (
        input  rom_en, rom_addr, x_valid, x_data,
        output rom_data, res_valid, res_class
    );
endinterface

// File: rtl/mlp_sched_result_buf.sv
// Packed classification store: one CLASS_W entry per image plus a count of
// entries written since the last clear.
module mlp_sched_result_buf
    import mlp_sched_pkg::*;
#(
    parameter int NUM_IMAGES = DEF_NUM_IMAGES,
    parameter int CLASS_W    = DEF_CLASS_W
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,
    input  logic                          clr,
    input  logic                          we,
    input  logic [7:0]                    idx,
    input  logic [CLASS_W-1:0]            wdata,
    output logic [NUM_IMAGES*CLASS_W-1:0] result_buf,
    output logic [7:0]                    result_count
);

    for (genvar i = 0; i < NUM_IMAGES; i++) begin : g_entry
        logic [CLASS_W-1:0] entry_q;

        // Each entry captures the class only when its own index is written.
        always_ff @(posedge s_axi_aclk) begin
            if (!s_axi_aresetn || clr) entry_q <= '0;
            else if (we && idx == 8'(i)) entry_q <= wdata;
        end

        assign result_buf[i*CLASS_W +: CLASS_W] = entry_q;
    end

    // Count of results stored this run.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn || clr) result_count <= '0;
        else if (we)               result_count <= result_count + 8'd1;
    end

endmodule

// File: rtl/mlp_image_sched.sv
// Image sequencer: streams images from ROM into MLP layer 1, collects one
// classification per image and reports start/busy/done.
// Optional watchdog on the result wait: define MLP_SCHED_WDOG_EN.
module mlp_image_sched
    import mlp_sched_pkg::*;
#(
    parameter int NUM_IMAGES  = DEF_NUM_IMAGES,
    parameter int IMAGE_SIZE  = DEF_IMAGE_SIZE,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CLASS_W     = DEF_CLASS_W,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,
    input  logic                          start,
    input  logic [7:0]                    num_images,
    mlp_image_sched_if.master             bus,
    output logic                          busy,
    output logic                          done,
    output logic [7:0]                    result_count,
    output logic [NUM_IMAGES*CLASS_W-1:0] result_buf,
    output logic                          timeout_err
);

    // ROM read issue -> ROM data valid -> registered layer input.
    localparam int STAGES = 2;
    // Word counter runs past the last issue until the read pipe has drained,
    // so WAIT_RES never overlaps a live x_valid.
    localparam int             K_W          = $clog2(IMAGE_SIZE + 2);
    localparam logic [K_W-1:0] K_LAST_ISSUE = K_W'(IMAGE_SIZE - 1);
    localparam logic [K_W-1:0] K_DRAINED    = K_W'(IMAGE_SIZE + 1);

    sched_state_e       state, state_nx;
    logic [7:0]         n_q, idx_q, n_clamped;
    logic [ADDR_W-1:0]  base_q, addr_q;
    logic [K_W-1:0]     k_q;
    logic [STAGES:0]    vld_pipe;
    logic [DATA_W-1:0]  x_data_q;
    logic               busy_q, done_q;

    logic               start_acc, issue_en, stream_end, take, last_img, wdog_fire;
    logic [CLASS_W-1:0] take_class;

    assign n_clamped = clamp_images(num_images, NUM_IMAGES);

`ifdef MLP_SCHED_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            tmo_q;

    // Result-wait watchdog; restarts each time an image finishes streaming.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            wd_cnt <= '0;
            tmo_q  <= 1'b0;
        end else begin
            if (stream_end)            wd_cnt <= '0;
            else if (state == WAIT_RES) wd_cnt <= wd_cnt + 1'b1;
            if (start_acc)      tmo_q <= 1'b0;
            else if (wdog_fire) tmo_q <= 1'b1;
        end
    end

    assign wdog_fire   = (state == WAIT_RES) && !bus.res_valid &&
                         (wd_cnt == WD_W'(WDOG_CYCLES - 1));
    assign timeout_err = tmo_q;
`else
    assign wdog_fire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) state <= IDLE;
        else                state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = (n_clamped == 8'd0) ? FINISH : PRIME;
            PRIME:    state_nx = STREAM;
            STREAM:   if (stream_end) state_nx = WAIT_RES;
            WAIT_RES: if (take) state_nx = last_img ? FINISH : PRIME;
            FINISH:   state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Control strobes decoded from the current state.
    always_comb begin
        start_acc  = (state == IDLE) && start;
        issue_en   = (state == PRIME) || ((state == STREAM) && (k_q < K_LAST_ISSUE));
        stream_end = (state == STREAM) && (k_q == K_DRAINED);
        take       = (state == WAIT_RES) && (bus.res_valid || wdog_fire);
        last_img   = (idx_q + 8'd1) == n_q;
        take_class = bus.res_valid ? bus.res_class : CLASS_W'(TIMEOUT_CLASS);
    end

    // Datapath: address generation, read pipe, image bookkeeping, handshake.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            vld_pipe <= '0;
            addr_q   <= '0;
            x_data_q <= '0;
            k_q      <= '0;
            n_q      <= '0;
            idx_q    <= '0;
            base_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], issue_en};
            if (issue_en)
                addr_q <= (state == PRIME) ? base_q
                                           : base_q + ADDR_W'(k_q) + ADDR_W'(1);
            if (vld_pipe[STAGES-1]) x_data_q <= bus.rom_data;

            if (state == PRIME)       k_q <= '0;
            else if (state == STREAM) k_q <= k_q + 1'b1;

            if (start_acc) begin
                n_q    <= n_clamped;
                idx_q  <= '0;
                base_q <= '0;
            end else if (take) begin
                idx_q  <= idx_q + 8'd1;
                base_q <= base_q + ADDR_W'(IMAGE_SIZE);
            end

            if (start_acc)            busy_q <= 1'b1;
            else if (state == FINISH) busy_q <= 1'b0;
            done_q <= (state == FINISH);
        end
    end

    mlp_sched_result_buf #(
        .NUM_IMAGES (NUM_IMAGES),
        .CLASS_W    (CLASS_W)
    ) u_result_buf (
        .s_axi_aclk    (s_axi_aclk),
        .s_axi_aresetn (s_axi_aresetn),
        .clr           (start_acc),
        .we            (take),
        .idx           (idx_q),
        .wdata         (take_class),
        .result_buf    (result_buf),
        .result_count  (result_count)
    );

    assign bus.rom_en   = vld_pipe[0];
    assign bus.rom_addr = addr_q;
    assign bus.x_valid  = vld_pipe[STAGES];
    assign bus.x_data   = x_data_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_mlp_image_sched.sv
// Directed bench for mlp_image_sched: ROM word = address, results driven by hand.
module tb_mlp_image_sched;

    localparam int NUM_IMAGES = 32;
    localparam int IMAGE_SIZE = 64;
    localparam int ADDR_W     = 13;
    localparam int DATA_W     = 16;
    localparam int CLASS_W    = 4;

    logic                          s_axi_aclk = 1'b0;
    logic                          s_axi_aresetn;
    logic                          start;
    logic [7:0]                    num_images;
    logic                          busy, done, timeout_err;
    logic [7:0]                    result_count;
    logic [NUM_IMAGES*CLASS_W-1:0] result_buf;

    always #5 s_axi_aclk = ~s_axi_aclk;

    mlp_image_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLASS_W(CLASS_W)) bus ();

    mlp_image_sched #(
        .NUM_IMAGES (NUM_IMAGES), .IMAGE_SIZE (IMAGE_SIZE), .ADDR_W (ADDR_W),
        .DATA_W (DATA_W), .CLASS_W (CLASS_W), .WDOG_CYCLES (16)
    ) dut (
        .s_axi_aclk    (s_axi_aclk),
        .s_axi_aresetn (s_axi_aresetn),
        .start         (start),
        .num_images    (num_images),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .result_count  (result_count),
        .result_buf    (result_buf),
        .timeout_err   (timeout_err)
    );

    // ROM: one-cycle read latency, word value equals its address.
    always @(posedge s_axi_aclk) if (bus.rom_en) bus.rom_data <= 16'(bus.rom_addr);

    int checks = 0;
    int errors = 0;

    logic [15:0]       xlog[$];
    int                blens[$];
    int                rom_cnt = 0, done_cnt = 0, cur_len = 0;
    logic              prev_xv = 1'b0;
    logic [ADDR_W-1:0] max_addr = '0;

    // Passive monitor sampled on the falling edge.
    always @(negedge s_axi_aclk) begin
        if (bus.x_valid === 1'b1) begin
            xlog.push_back(bus.x_data);
            cur_len++;
        end else if (prev_xv) begin
            blens.push_back(cur_len);
            cur_len = 0;
        end
        prev_xv = (bus.x_valid === 1'b1);
        if (bus.rom_en === 1'b1) begin
            rom_cnt++;
            if (bus.rom_addr > max_addr) max_addr = bus.rom_addr;
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge s_axi_aclk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] n);
        start = 1'b1;
        num_images = n;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_words(input int target, input string nm);
        int cyc = 0;
        while (xlog.size() < target && cyc < 400) begin
            tick();
            cyc++;
        end
        checks++;
        if (xlog.size() < target) begin
            errors++;
            $display("FAIL %s words got %0d exp %0d", nm, xlog.size(), target);
        end
    endtask

    task automatic wait_done(input int d0, input string nm);
        int cyc = 0;
        while (done_cnt == d0 && cyc < 400) begin
            tick();
            cyc++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s no done pulse within %0d cycles", nm, cyc);
        end
    endtask

    task automatic send_result(input logic [3:0] cls);
        tick();
        bus.res_valid = 1'b1;
        bus.res_class = cls;
        tick();
        bus.res_valid = 1'b0;
    endtask

    task automatic test_reset();
        s_axi_aresetn = 1'b0;
        start = 1'b0;
        num_images = 8'd0;
        bus.res_valid = 1'b0;
        bus.res_class = '0;
        repeat (3) tick();
        checks++;
        if ({busy, done, bus.rom_en, bus.x_valid, timeout_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 00000", {busy, done, bus.rom_en, bus.x_valid, timeout_err});
        end
        checks++;
        if (result_count !== 8'd0 || result_buf !== '0) begin
            errors++;
            $display("FAIL reset_buf got cnt %0d buf %h exp 0", result_count, result_buf);
        end
        s_axi_aresetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int xb = xlog.size();
        int bb = blens.size();
        int d0 = done_cnt;
        int bad = 0;
        logic [3:0] cls [3] = '{4'd7, 4'd2, 4'd9};
        pulse_start(8'd3);
        checks++;
        if (busy !== 1'b1 || bus.rom_en !== 1'b0) begin
            errors++;
            $display("FAIL lat_edge0 got busy %b rom_en %b exp 1 0", busy, bus.rom_en);
        end
        tick();
        checks++;
        if (bus.rom_en !== 1'b1 || bus.rom_addr !== 13'd0) begin
            errors++;
            $display("FAIL lat_edge1 got rom_en %b addr %0d exp 1 0", bus.rom_en, bus.rom_addr);
        end
        tick();
        checks++;
        if (bus.x_valid !== 1'b0 || bus.rom_addr !== 13'd1) begin
            errors++;
            $display("FAIL lat_edge2 got x_valid %b addr %0d exp 0 1", bus.x_valid, bus.rom_addr);
        end
        tick();
        checks++;
        if (bus.x_valid !== 1'b1 || bus.x_data !== 16'd0) begin
            errors++;
            $display("FAIL lat_edge3 got x_valid %b data %0d exp 1 0", bus.x_valid, bus.x_data);
        end
        for (int img = 0; img < 3; img++) begin
            wait_words(xb + 64 * (img + 1), "basic_words");
            send_result(cls[img]);
        end
        wait_done(d0, "basic_done");
        checks++;
        if (result_buf[11:0] !== 12'h927 || result_count !== 8'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_result got buf %h cnt %0d busy %b exp 927 3 0", result_buf[11:0], result_count, busy);
        end
        for (int i = 0; i < 192; i++) if (xlog[xb + i] !== 16'(i)) bad++;
        checks++;
        if (bad != 0 || xlog.size() - xb != 192) begin
            errors++;
            $display("FAIL basic_data got %0d bad words of %0d exp 0 of 192", bad, xlog.size() - xb);
        end
        checks++;
        if (blens.size() - bb != 3 || blens[bb] != 64 || blens[bb + 1] != 64 || blens[bb + 2] != 64) begin
            errors++;
            $display("FAIL basic_bursts got %0d bursts exp 3 of 64", blens.size() - bb);
        end
        repeat (3) tick();
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL basic_done_once got %0d exp 1", done_cnt - d0);
        end
    endtask

    task automatic test_stray_result();
        int xb = xlog.size();
        int d0 = done_cnt;
        pulse_start(8'd1);
        wait_words(xb + 10, "stray_mid");
        bus.res_valid = 1'b1;
        bus.res_class = 4'd3;
        tick();
        bus.res_valid = 1'b0;
        wait_words(xb + 64, "stray_words");
        checks++;
        if (busy !== 1'b1 || result_count !== 8'd0) begin
            errors++;
            $display("FAIL stray_ignored got busy %b cnt %0d exp 1 0", busy, result_count);
        end
        send_result(4'd5);
        wait_done(d0, "stray_done");
        checks++;
        if (result_buf[3:0] !== 4'd5 || result_count !== 8'd1 || xlog.size() - xb != 64) begin
            errors++;
            $display("FAIL stray_result got e0 %0d cnt %0d words %0d exp 5 1 64", result_buf[3:0], result_count, xlog.size() - xb);
        end
    endtask

    task automatic test_zero_images();
        int rc0 = rom_cnt;
        start = 1'b1;
        num_images = 8'd0;
        bus.res_valid = 1'b1;
        bus.res_class = 4'hA;
        tick();
        start = 1'b0;
        bus.res_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL zero_edge0 got busy %b done %b exp 1 0", busy, done);
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done got done %b busy %b exp 1 0", done, busy);
        end
        checks++;
        if (result_count !== 8'd0 || result_buf !== '0) begin
            errors++;
            $display("FAIL zero_cleared got cnt %0d buf %h exp 0", result_count, result_buf);
        end
        tick();
        checks++;
        if (done !== 1'b0 || rom_cnt != rc0) begin
            errors++;
            $display("FAIL zero_no_rom got done %b reads %0d exp 0 0", done, rom_cnt - rc0);
        end
    endtask

    task automatic test_clamp();
        int xb = xlog.size();
        int rc0 = rom_cnt;
        int d0 = done_cnt;
        int bad = 0;
        pulse_start(8'd40);
        for (int i = 0; i < 32; i++) begin
            wait_words(xb + 64 * (i + 1), "clamp_words");
            send_result(4'(i));
        end
        wait_done(d0, "clamp_done");
        checks++;
        if (result_count !== 8'd32 || result_buf !== 128'hFEDCBA9876543210FEDCBA9876543210) begin
            errors++;
            $display("FAIL clamp_result got cnt %0d buf %h exp 32 FEDCBA9876543210FEDCBA9876543210", result_count, result_buf);
        end
        checks++;
        if (rom_cnt - rc0 != 2048 || max_addr !== 13'd2047) begin
            errors++;
            $display("FAIL clamp_rom got reads %0d max %0d exp 2048 2047", rom_cnt - rc0, max_addr);
        end
        for (int i = 0; i < 2048; i++) if (xlog[xb + i] !== 16'(i)) bad++;
        checks++;
        if (bad != 0 || xlog.size() - xb != 2048) begin
            errors++;
            $display("FAIL clamp_data got %0d bad of %0d exp 0 of 2048", bad, xlog.size() - xb);
        end
    endtask

    task automatic test_busy_ignore();
        int xb = xlog.size();
        int d0 = done_cnt;
        int bad = 0;
        pulse_start(8'd2);
        wait_words(xb + 20, "busy_mid");
        pulse_start(8'd5);
        num_images = 8'd7;
        wait_words(xb + 64, "busy_img0");
        send_result(4'd1);
        wait_words(xb + 100, "busy_img1");
        pulse_start(8'd9);
        wait_words(xb + 128, "busy_words");
        send_result(4'd4);
        wait_done(d0, "busy_done");
        repeat (4) tick();
        checks++;
        if (result_count !== 8'd2 || result_buf[7:0] !== 8'h41 || result_buf[127:8] !== '0) begin
            errors++;
            $display("FAIL busy_result got cnt %0d buf %h exp 2 41", result_count, result_buf);
        end
        for (int i = 0; i < 128; i++) if (xlog[xb + i] !== 16'(i)) bad++;
        checks++;
        if (bad != 0 || xlog.size() - xb != 128 || done_cnt - d0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_norestart got bad %0d words %0d dones %0d busy %b exp 0 128 1 0", bad, xlog.size() - xb, done_cnt - d0, busy);
        end
    endtask

    task automatic test_reset_mid();
        int xb = xlog.size();
        int rc0, d0;
        int bad = 0;
        pulse_start(8'd2);
        wait_words(xb + 64, "rstmid_img0");
        send_result(4'd6);
        wait_words(xb + 69, "rstmid_img1");
        s_axi_aresetn = 1'b0;
        tick();
        checks++;
        if ({busy, done, bus.rom_en, bus.x_valid, timeout_err} !== 5'b0 ||
            bus.rom_addr !== '0 || bus.x_data !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got ctrl %b addr %0d data %0d exp 0", {busy, done, bus.rom_en, bus.x_valid, timeout_err}, bus.rom_addr, bus.x_data);
        end
        checks++;
        if (result_count !== 8'd0 || result_buf !== '0) begin
            errors++;
            $display("FAIL rstmid_buf got cnt %0d buf %h exp 0", result_count, result_buf);
        end
        rc0 = rom_cnt;
        tick();
        s_axi_aresetn = 1'b1;
        repeat (5) tick();
        checks++;
        if (rom_cnt != rc0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle got reads %0d busy %b exp 0 0", rom_cnt - rc0, busy);
        end
        xb = xlog.size();
        d0 = done_cnt;
        pulse_start(8'd1);
        tick();
        checks++;
        if (bus.rom_en !== 1'b1 || bus.rom_addr !== 13'd0) begin
            errors++;
            $display("FAIL rstmid_restart got rom_en %b addr %0d exp 1 0", bus.rom_en, bus.rom_addr);
        end
        wait_words(xb + 64, "rstmid_rerun");
        send_result(4'd8);
        wait_done(d0, "rstmid_done");
        for (int i = 0; i < 64; i++) if (xlog[xb + i] !== 16'(i)) bad++;
        checks++;
        if (bad != 0 || result_buf[3:0] !== 4'd8 || result_count !== 8'd1) begin
            errors++;
            $display("FAIL rstmid_rerun got bad %0d e0 %0d cnt %0d exp 0 8 1", bad, result_buf[3:0], result_count);
        end
    endtask

    task automatic test_wdog();
        int xb = xlog.size();
        int d0 = done_cnt;
`ifdef MLP_SCHED_WDOG_EN
        pulse_start(8'd2);
        wait_words(xb + 64, "wdog_img0");
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL wdog_early got %b exp 0", timeout_err);
        end
        wait_words(xb + 128, "wdog_img1");
        checks++;
        if (timeout_err !== 1'b1 || result_count !== 8'd1 || result_buf[3:0] !== 4'hF) begin
            errors++;
            $display("FAIL wdog_fire got err %b cnt %0d e0 %h exp 1 1 f", timeout_err, result_count, result_buf[3:0]);
        end
        send_result(4'd3);
        wait_done(d0, "wdog_done");
        checks++;
        if (result_buf[7:0] !== 8'h3F || result_count !== 8'd2 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL wdog_result got buf %h cnt %0d err %b exp 3f 2 1", result_buf[7:0], result_count, timeout_err);
        end
`else
        pulse_start(8'd1);
        wait_words(xb + 64, "wait_img0");
        repeat (200) tick();
        checks++;
        if (busy !== 1'b1 || done_cnt != d0 || timeout_err !== 1'b0 || result_count !== 8'd0) begin
            errors++;
            $display("FAIL wait_forever got busy %b dones %0d err %b cnt %0d exp 1 0 0 0", busy, done_cnt - d0, timeout_err, result_count);
        end
        send_result(4'd3);
        wait_done(d0, "wait_done");
        checks++;
        if (result_buf[3:0] !== 4'd3 || result_count !== 8'd1) begin
            errors++;
            $display("FAIL wait_result got e0 %0d cnt %0d exp 3 1", result_buf[3:0], result_count);
        end
`endif
        pulse_start(8'd0);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL wdog_clear got %b exp 0", timeout_err);
        end
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stray_result();
        test_zero_images();
        test_clamp();
        test_busy_ignore();
        test_reset_mid();
        test_wdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/mlp_image_sched.md
Name: mlp_image_sched

Overview:
Sequencer between the input image ROM and the first MLP layer.
- On a start pulse it streams a programmable number of images, word by word, into the layer-1 input port.
- After each image it waits for the classification from the max-finder stage and stores it in a packed result buffer.
- It then advances to the next image and finishes with a done pulse.
- It replaces the ad-hoc ROM/LCD sequencing in the top level with a clean start/busy/done handshake.

Parameters:
- NUM_IMAGES, 32, images held in ROM; upper clamp for num_images.
- IMAGE_SIZE, 64, words per image.
- ADDR_W, 13, ROM address width; must satisfy NUM_IMAGES*IMAGE_SIZE <= 2**ADDR_W.
- DATA_W, 16, ROM word / layer input width.
- CLASS_W, 4, classification index width.
- WDOG_CYCLES, 4096, result timeout; used only with the optional feature.

Ports:
- s_axi_aclk  in  1  clock.
- s_axi_aresetn  in  1  synchronous active-low reset.
- start  in  1  single-cycle run request.
- num_images  in  8  images to run; sampled only when start is accepted.
- rom_en  out  1  ROM read enable.
- rom_addr  out  ADDR_W  ROM read address.
- rom_data  in  DATA_W  ROM read data, valid 1 cycle after rom_en/rom_addr.
- x_valid  out  1  layer-1 input strobe.
- x_data  out  DATA_W  layer-1 input word.
- res_valid  in  1  max-finder result strobe.
- res_class  in  CLASS_W  max-finder class index.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- result_count  out  8  results stored this run.
- result_buf  out  NUM_IMAGES*CLASS_W  entry i at bits [i*CLASS_W +: CLASS_W].
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (s_axi_aresetn low at a clock edge): all outputs 0 and state IDLE. Reset mid-run aborts immediately; the buffer is cleared and the ROM is not read again.
- States:
  - IDLE: busy=0. Start accepted only here. Latch n = min(num_images, NUM_IMAGES). Clear result_buf, result_count and timeout_err. If n=0, go to FINISH; otherwise go to PRIME with image index 0 and base 0.
  - PRIME (1 cycle): rom_en=1, rom_addr=base, word counter=0. Next state STREAM.
  - STREAM: rom_en=1 and rom_addr=base+k+1 while k < IMAGE_SIZE-1. Each cycle register x_data<=rom_data and x_valid<=1.
    - Exactly IMAGE_SIZE consecutive x_valid cycles per image, words in ascending address order, no gaps.
    - After the last word: rom_en=0, go to WAIT_RES.
  - WAIT_RES: x_valid=0. On the first res_valid, write res_class to entry idx, increment result_count and idx, and add IMAGE_SIZE to base (accumulator, no multiplier). If idx+1 == n go to FINISH, else go to PRIME.
  - FINISH (1 cycle): done=1, busy=0 next cycle, return to IDLE. result_buf and result_count hold until the next accepted start.
- busy=1 from the cycle after start is accepted until FINISH.
- Latency: start sampled at edge 0; rom_en at edge 1; first x_valid visible after edge 3.
- res_valid outside WAIT_RES is ignored. This covers stale or pipeline-flush outputs, including any result arriving while streaming.
- start while busy is ignored; num_images changes mid-run have no effect.
- res_valid and start in the same cycle in IDLE: start is processed and res_valid is ignored.
- rom_addr never exceeds NUM_IMAGES*IMAGE_SIZE-1.

Optional Feature:
MLP_SCHED_WDOG_EN.
- Defined: a counter runs in WAIT_RES. If WDOG_CYCLES cycles elapse with no res_valid, the controller:
  - stores all-ones (4'hF) in the entry;
  - sets timeout_err (sticky until the next accepted start or reset);
  - advances exactly as on a normal result.
  The counter clears on entering WAIT_RES.
- Undefined: WAIT_RES waits indefinitely, timeout_err is tied 0 and no counter is synthesized.

Decomposition:
- Package mlp_sched_pkg holds:
  - state encoding constants (IDLE, PRIME, STREAM, WAIT_RES, FINISH);
  - default NUM_IMAGES, IMAGE_SIZE, ADDR_W, DATA_W, CLASS_W;
  - the TIMEOUT_CLASS all-ones constant.
- One sub-module, mlp_sched_result_buf, holds the packed result register with write-enable, index, clear and count.

Test Plan:
- start with num_images=3, ROM word = address -> 192 x_valid cycles in 3 bursts of 64 (data 0..63, 64..127, 128..191). Results 7, 2, 9 give result_buf[11:0]=12'h927, result_count=3, one done pulse.
- res_valid pulse during STREAM of image 0, then real result 5 -> stray pulse ignored, entry 0 = 5, count=1 after image 0.
- num_images=0 -> done one cycle after PRIME would have occurred; no rom_en; result_count=0. num_images=40 -> clamped to 32, last rom_addr=2047.
- start pulses while busy, plus num_images changed mid-run -> run length unchanged, no restart.
- s_axi_aresetn low during STREAM of image 1 -> next cycle all outputs 0, IDLE. A subsequent start with n=1 runs cleanly from address 0.
- MLP_SCHED_WDOG_EN, WDOG_CYCLES=16, no res_valid for image 0 of 2 -> entry 0 = 4'hF, timeout_err=1, image 1 streams normally. Without the macro the bench observes an indefinite wait.
